// File: rtl/seg_display_scheduler_pkg.sv
// -----------------------------------------------------------------------------
// seg_disp_pkg
// Shared types for the seven-segment display scheduler.
//   state_t  : scheduler FSM states
//   SEL_SINE : display select value for the sine channel
//   SEL_COS  : display select value for the cosine channel
// -----------------------------------------------------------------------------
package seg_disp_pkg;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      SHOW_SINE = 2'd1,
      SHOW_COS  = 2'd2,
      HOLD      = 2'd3
   } state_t;

   localparam logic SEL_SINE = 1'b0;
   localparam logic SEL_COS  = 1'b1;

endpackage

// File: rtl/seg_display_scheduler_debouncer.sv
// -----------------------------------------------------------------------------
// button_debouncer
// Synchronizes a raw pushbutton and filters contact bounce.
//   clock      : system clock
//   reset      : asynchronous, active-high reset
//   raw        : asynchronous pushbutton input
//   level      : debounced button level
//   rise_pulse : one-cycle pulse in the cycle after level goes 0 -> 1
// The synchronized level must differ from the accepted level for
// DEBOUNCE_CYCLES consecutive samples before it is taken over.
// -----------------------------------------------------------------------------
module button_debouncer #(
   parameter int DEBOUNCE_CYCLES = 1_000_000
) (
   input  logic clock,
   input  logic reset,
   input  logic raw,
   output logic level,
   output logic rise_pulse
);

   localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic [1:0]       sync;
   logic [CNT_W-1:0] stable_cnt;
   logic             level_q;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         sync       <= '0;
         stable_cnt <= '0;
         level      <= 1'b0;
         level_q    <= 1'b0;
      end else begin
         sync    <= {sync[0], raw};
         level_q <= level;
         // Any sample agreeing with the current level restarts the count,
         // so a glitch shorter than DEBOUNCE_CYCLES never reaches CNT_LAST.
         if (sync[1] == level) begin
            stable_cnt <= '0;
         end else if (stable_cnt == CNT_LAST) begin
            level      <= sync[1];
            stable_cnt <= '0;
         end else begin
            stable_cnt <= stable_cnt + 1'b1;
         end
      end
   end

   // Both terms are registers, so the pulse is glitch-free.
   assign rise_pulse = level & ~level_q;

endmodule

// File: rtl/seg_display_scheduler.sv
// -----------------------------------------------------------------------------
// seg_display_scheduler
// Shares one 4-digit display between the sine and cosine sources.
//   clock_100Mhz : system clock
//   reset        : asynchronous, active-high reset
//   btn_next     : raw pushbutton, advance to the other channel
//   btn_hold     : raw pushbutton, toggle freeze
//   sine_valid / sine     : sine sample strobe and data
//   cosine_valid / cosine : cosine sample strobe and data
//   sine_ack / cosine_ack : one-cycle accept pulses (registered)
//   sel          : 0 = sine, 1 = cosine (display selIn)
//   shown_value  : latched sample of the displayed channel
//   hold_led     : high while frozen
// -----------------------------------------------------------------------------
module seg_display_scheduler
   import seg_disp_pkg::*;
#(
   parameter int DWELL_CYCLES    = 200_000_000,
   parameter int DEBOUNCE_CYCLES = 1_000_000
) (
   input  logic        clock_100Mhz,
   input  logic        reset,
   input  logic        btn_next,
   input  logic        btn_hold,
   input  logic        sine_valid,
   input  logic [15:0] sine,
   input  logic        cosine_valid,
   input  logic [15:0] cosine,
   output logic        sine_ack,
   output logic        cosine_ack,
   output logic        sel,
   output logic [15:0] shown_value,
   output logic        hold_led
);

   localparam int DW_W = (DWELL_CYCLES > 1) ? $clog2(DWELL_CYCLES) : 1;
   localparam logic [DW_W-1:0] DWELL_LAST = DW_W'(DWELL_CYCLES - 1);

   state_t            state, state_n;
   logic [DW_W-1:0]   dwell_cnt, dwell_n;
   logic              seen_sine, seen_sine_n;
   logic              seen_cos, seen_cos_n;
   logic              sel_n;
   logic [15:0]       shown_n;
   logic              sine_ack_n, cosine_ack_n;

   logic              next_lvl, next_rise_raw;
   logic              hold_lvl, hold_rise_raw;
   logic              next_rise, hold_rise;

   logic              cur_valid, other_seen, dwell_done;
   logic [15:0]       cur_data;

   button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_next_db (
      .clock      (clock_100Mhz),
      .reset      (reset),
      .raw        (btn_next),
      .level      (next_lvl),
      .rise_pulse (next_rise_raw)
   );

   button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_hold_db (
      .clock      (clock_100Mhz),
      .reset      (reset),
      .raw        (btn_hold),
      .level      (hold_lvl),
      .rise_pulse (hold_rise_raw)
   );

   // A rise event is only meaningful while the debounced level is high.
   assign next_rise = next_rise_raw & next_lvl;
   assign hold_rise = hold_rise_raw & hold_lvl;

   // Displayed-channel view, selected by the current sel register.
   assign cur_valid  = (sel == SEL_COS) ? cosine_valid : sine_valid;
   assign cur_data   = (sel == SEL_COS) ? cosine       : sine;
   assign other_seen = (sel == SEL_COS) ? seen_sine    : seen_cos;
   assign dwell_done = (dwell_cnt == DWELL_LAST);

   always_ff @(posedge clock_100Mhz or posedge reset) begin
      if (reset) begin
         state       <= IDLE;
         dwell_cnt   <= '0;
         seen_sine   <= 1'b0;
         seen_cos    <= 1'b0;
         sel         <= SEL_SINE;
         shown_value <= '0;
         sine_ack    <= 1'b0;
         cosine_ack  <= 1'b0;
      end else begin
         state       <= state_n;
         dwell_cnt   <= dwell_n;
         seen_sine   <= seen_sine_n;
         seen_cos    <= seen_cos_n;
         sel         <= sel_n;
         shown_value <= shown_n;
         sine_ack    <= sine_ack_n;
         cosine_ack  <= cosine_ack_n;
      end
   end

   always_comb begin
      state_n      = state;
      dwell_n      = dwell_cnt;
      sel_n        = sel;
      shown_n      = shown_value;
      sine_ack_n   = 1'b0;
      cosine_ack_n = 1'b0;
      // A source counts as present once it has produced any valid.
      seen_sine_n  = seen_sine | sine_valid;
      seen_cos_n   = seen_cos  | cosine_valid;

      case (state)
         IDLE: begin
            dwell_n = '0;
            // Sine wins a tie; the cosine valid then only marks it seen.
            if (sine_valid) begin
               state_n    = SHOW_SINE;
               sel_n      = SEL_SINE;
               shown_n    = sine;
               sine_ack_n = 1'b1;
            end else if (cosine_valid) begin
               state_n      = SHOW_COS;
               sel_n        = SEL_COS;
               shown_n      = cosine;
               cosine_ack_n = 1'b1;
            end
         end

         SHOW_SINE, SHOW_COS: begin
            if (hold_rise) begin
               // Hold beats a simultaneous next; counter and outputs freeze.
               state_n = HOLD;
            end else begin
               if (cur_valid) begin
                  shown_n      = cur_data;
                  sine_ack_n   = (sel == SEL_SINE);
                  cosine_ack_n = (sel == SEL_COS);
               end
               dwell_n = dwell_cnt + 1'b1;
               // Expiry and a button press in the same cycle merge into a
               // single switch request.
               if (dwell_done || next_rise) begin
                  dwell_n = '0;
                  if (other_seen) begin
                     sel_n   = ~sel;
                     state_n = (sel == SEL_COS) ? SHOW_SINE : SHOW_COS;
                  end
               end
            end
         end

         HOLD: begin
            if (hold_rise) begin
               state_n = (sel == SEL_COS) ? SHOW_COS : SHOW_SINE;
               dwell_n = '0;
            end
         end

         default: state_n = IDLE;
      endcase
   end

   assign hold_led = (state == HOLD);

endmodule

// File: tb/tb_seg_display_scheduler.sv
module tb_seg_display_scheduler;
   import seg_disp_pkg::*;

   logic        clock_100Mhz;
   logic        reset;
   logic        btn_next, btn_hold;
   logic        sine_valid, cosine_valid;
   logic [15:0] sine, cosine;
   logic        sine_ack, cosine_ack, sel, hold_led;
   logic [15:0] shown_value;

   int errors = 0;
   int checks = 0;
   int ack_cnt = 0;
   int ack_base;

   seg_display_scheduler #(.DWELL_CYCLES(20), .DEBOUNCE_CYCLES(4)) dut (
      .clock_100Mhz (clock_100Mhz),
      .reset        (reset),
      .btn_next     (btn_next),
      .btn_hold     (btn_hold),
      .sine_valid   (sine_valid),
      .sine         (sine),
      .cosine_valid (cosine_valid),
      .cosine       (cosine),
      .sine_ack     (sine_ack),
      .cosine_ack   (cosine_ack),
      .sel          (sel),
      .shown_value  (shown_value),
      .hold_led     (hold_led)
   );

   initial begin
      clock_100Mhz = 1'b0;
      forever #5 clock_100Mhz = ~clock_100Mhz;
   end

   always @(negedge clock_100Mhz) begin
      if (sine_ack || cosine_ack) ack_cnt <= ack_cnt + 1;
   end

   // Advance n edges; inputs are driven and outputs sampled 1 ns after an edge.
   task automatic cyc(input int n);
      repeat (n) begin
         @(posedge clock_100Mhz);
         #1;
      end
   endtask

   task automatic apply_reset();
      reset = 1'b1;
      btn_next = 0; btn_hold = 0;
      sine_valid = 0; cosine_valid = 0;
      sine = '0; cosine = '0;
      cyc(2);
      reset = 1'b0;
      cyc(2);
   endtask

   // Ends right after edge A+1: SHOW_SINE, shown 0x1234, dwell 1, cosine seen.
   task automatic start_both();
      apply_reset();
      sine_valid = 1; sine = 16'h1234;
      cyc(1);
      sine_valid = 0; cosine_valid = 1; cosine = 16'hABCD;
      cyc(1);
      cosine_valid = 0;
   endtask

   task automatic test_reset();
      apply_reset();
      ack_base = ack_cnt;
      cyc(100);
      checks++; if (dut.state !== IDLE) begin errors++; $display("FAIL reset_state got=%0d exp=%0d", dut.state, IDLE); end
      checks++; if (sel !== 1'b0) begin errors++; $display("FAIL reset_sel got=%b exp=0", sel); end
      checks++; if (shown_value !== 16'h0000) begin errors++; $display("FAIL reset_shown got=%h exp=0000", shown_value); end
      checks++; if (hold_led !== 1'b0) begin errors++; $display("FAIL reset_hold_led got=%b exp=0", hold_led); end
      checks++; if (ack_cnt !== ack_base) begin errors++; $display("FAIL reset_acks got=%0d exp=0", ack_cnt - ack_base); end
   endtask

   task automatic test_rotation();
      apply_reset();
      sine_valid = 1; sine = 16'h1234;
      cyc(1);
      sine_valid = 0;
      checks++; if (sine_ack !== 1'b1 || cosine_ack !== 1'b0) begin errors++; $display("FAIL first_ack got=%b%b exp=10", sine_ack, cosine_ack); end
      checks++; if (shown_value !== 16'h1234) begin errors++; $display("FAIL first_shown got=%h exp=1234", shown_value); end
      for (int e = 1; e <= 25; e++) begin
         sine_valid   = (e % 5 == 0) && (e != 20);
         cosine_valid = (e == 1) || ((e % 5 == 0) && (e != 20));
         sine = 16'h1234; cosine = 16'hABCD;
         cyc(1);
         sine_valid = 0; cosine_valid = 0;
         if (e == 1) begin
            checks++; if (cosine_ack !== 1'b0 || sine_ack !== 1'b0) begin errors++; $display("FAIL nondisp_noack got=%b%b exp=00", sine_ack, cosine_ack); end
         end
         if (e % 5 == 0 && e < 20) begin
            checks++; if (sine_ack !== 1'b1 || cosine_ack !== 1'b0) begin errors++; $display("FAIL sine_acks e=%0d got=%b%b exp=10", e, sine_ack, cosine_ack); end
            checks++; if (shown_value !== 16'h1234) begin errors++; $display("FAIL sine_shown e=%0d got=%h exp=1234", e, shown_value); end
         end
         if (e == 19) begin
            checks++; if (sel !== 1'b0) begin errors++; $display("FAIL pre_dwell_sel got=%b exp=0", sel); end
         end
         if (e == 20) begin
            checks++; if (sel !== 1'b1) begin errors++; $display("FAIL dwell_switch_sel got=%b exp=1", sel); end
            checks++; if (shown_value !== 16'h1234) begin errors++; $display("FAIL switch_keeps_shown got=%h exp=1234", shown_value); end
         end
         if (e == 25) begin
            checks++; if (sine_ack !== 1'b0 || cosine_ack !== 1'b1) begin errors++; $display("FAIL cos_ack got=%b%b exp=01", sine_ack, cosine_ack); end
            checks++; if (shown_value !== 16'hABCD) begin errors++; $display("FAIL cos_shown got=%h exp=abcd", shown_value); end
         end
      end
   endtask

   task automatic test_cos_absent();
      apply_reset();
      sine_valid = 1; sine = 16'h1234;
      cyc(1);
      sine_valid = 0;
      for (int e = 1; e <= 62; e++) begin
         if (e == 62) begin sine_valid = 1; sine = 16'h5555; end
         cyc(1);
         sine_valid = 0;
         if (e % 20 == 0) begin
            checks++; if (sel !== 1'b0) begin errors++; $display("FAIL no_cos_sel e=%0d got=%b exp=0", e, sel); end
         end
      end
      checks++; if (sine_ack !== 1'b1 || shown_value !== 16'h5555) begin errors++; $display("FAIL no_cos_latch got=%b/%h exp=1/5555", sine_ack, shown_value); end
   endtask

   task automatic test_btn_next();
      start_both();                              // at A+1
      for (int i = 0; i < 3; i++) begin
         btn_next = 1; cyc(2);
         btn_next = 0; cyc(2);
      end                                        // A+13
      cyc(4);                                    // A+17
      checks++; if (sel !== 1'b0) begin errors++; $display("FAIL bounce_sel got=%b exp=0", sel); end
      cyc(3);                                    // A+20, dwell switch
      checks++; if (sel !== 1'b1) begin errors++; $display("FAIL bounce_dwell_sel got=%b exp=1", sel); end
      btn_next = 1;
      cyc(6);
      checks++; if (sel !== 1'b1) begin errors++; $display("FAIL next_early_sel got=%b exp=1", sel); end
      cyc(1);                                    // press + 7
      checks++; if (sel !== 1'b0) begin errors++; $display("FAIL next_switch_sel got=%b exp=0", sel); end
      cyc(3);
      btn_next = 0;
      cyc(10);
      checks++; if (sel !== 1'b0) begin errors++; $display("FAIL next_single_sel got=%b exp=0", sel); end
   endtask

   task automatic test_hold();
      start_both();                              // A+1
      cyc(19);                                   // A+20
      checks++; if (sel !== 1'b1) begin errors++; $display("FAIL hold_setup_sel got=%b exp=1", sel); end
      cosine_valid = 1; cosine = 16'hABCD;
      cyc(1);                                    // A+21
      cosine_valid = 0;
      checks++; if (cosine_ack !== 1'b1 || shown_value !== 16'hABCD) begin errors++; $display("FAIL hold_setup_cos got=%b/%h exp=1/abcd", cosine_ack, shown_value); end
      btn_hold = 1;
      cyc(6);
      checks++; if (hold_led !== 1'b0) begin errors++; $display("FAIL hold_early got=%b exp=0", hold_led); end
      cyc(1);                                    // A+28
      checks++; if (hold_led !== 1'b1) begin errors++; $display("FAIL hold_enter got=%b exp=1", hold_led); end
      cyc(3);
      btn_hold = 0;
      cyc(7);
      ack_base = ack_cnt;
      cosine_valid = 1; cosine = 16'h0001;
      cyc(1);
      cosine_valid = 0;
      checks++; if (cosine_ack !== 1'b0 || shown_value !== 16'hABCD) begin errors++; $display("FAIL hold_valid got=%b/%h exp=0/abcd", cosine_ack, shown_value); end
      btn_next = 1;                              // must be ignored in HOLD
      cyc(10);
      btn_next = 0;
      cyc(30);
      checks++; if (sel !== 1'b1 || shown_value !== 16'hABCD || hold_led !== 1'b1) begin
         errors++; $display("FAIL hold_frozen got=%b/%h/%b exp=1/abcd/1", sel, shown_value, hold_led); end
      checks++; if (ack_cnt !== ack_base) begin errors++; $display("FAIL hold_acks got=%0d exp=0", ack_cnt - ack_base); end
      btn_hold = 1;
      cyc(7);
      checks++; if (hold_led !== 1'b0 || sel !== 1'b1) begin errors++; $display("FAIL hold_exit got=%b/%b exp=0/1", hold_led, sel); end
      cyc(3);
      btn_hold = 0;
      cyc(16);
      checks++; if (sel !== 1'b1) begin errors++; $display("FAIL hold_dwell_early got=%b exp=1", sel); end
      cyc(1);
      checks++; if (sel !== 1'b0) begin errors++; $display("FAIL hold_dwell_full got=%b exp=0", sel); end
   endtask

   task automatic test_simultaneous();
      start_both();                              // A+1
      cyc(12);                                   // A+13
      btn_next = 1;
      cyc(7);                                    // A+20: expiry and rise together
      checks++; if (sel !== 1'b1) begin errors++; $display("FAIL simul_switch got=%b exp=1", sel); end
      cyc(3);
      btn_next = 0;
      cyc(16);                                   // A+39
      checks++; if (sel !== 1'b1) begin errors++; $display("FAIL simul_single got=%b exp=1", sel); end
      cyc(1);                                    // A+40
      checks++; if (sel !== 1'b0) begin errors++; $display("FAIL simul_next_dwell got=%b exp=0", sel); end
      start_both();                              // A+1
      btn_next = 1; btn_hold = 1;
      cyc(7);
      checks++; if (hold_led !== 1'b1 || sel !== 1'b0) begin errors++; $display("FAIL both_btn got=%b/%b exp=1/0", hold_led, sel); end
      btn_next = 0; btn_hold = 0;
      cyc(10);
      checks++; if (hold_led !== 1'b1 || sel !== 1'b0) begin errors++; $display("FAIL both_btn_stay got=%b/%b exp=1/0", hold_led, sel); end
   endtask

   task automatic test_reset_mid();
      start_both();
      cyc(19);                                   // A+20, SHOW_COS
      cosine_valid = 1; cosine = 16'hABCD;
      cyc(6);
      checks++; if (cosine_ack !== 1'b1 || sel !== 1'b1) begin errors++; $display("FAIL mid_setup got=%b/%b exp=1/1", cosine_ack, sel); end
      reset = 1'b1;
      #1;
      checks++; if (sel !== 1'b0 || shown_value !== 16'h0000 || hold_led !== 1'b0 || sine_ack !== 1'b0 || cosine_ack !== 1'b0) begin
         errors++; $display("FAIL mid_reset_async got=%b/%h/%b/%b%b exp=0/0000/0/00", sel, shown_value, hold_led, sine_ack, cosine_ack); end
      ack_base = ack_cnt;
      cyc(3);
      checks++; if (ack_cnt !== ack_base || dut.state !== IDLE) begin errors++; $display("FAIL mid_reset_hold got=%0d/%0d exp=0/%0d", ack_cnt - ack_base, dut.state, IDLE); end
      cosine_valid = 0;
      reset = 1'b0;
      cyc(2);
      checks++; if (dut.state !== IDLE || cosine_ack !== 1'b0) begin errors++; $display("FAIL post_reset got=%0d/%b exp=%0d/0", dut.state, cosine_ack, IDLE); end
   endtask

   initial begin
      reset = 1'b1;
      btn_next = 0; btn_hold = 0;
      sine_valid = 0; cosine_valid = 0;
      sine = '0; cosine = '0;
      test_reset();
      test_rotation();
      test_cos_absent();
      test_btn_next();
      test_hold();
      test_simultaneous();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout got=running exp=finished");
      $fatal(1);
   end

endmodule
